mul8_seq_ctrl: RTL and testbench

Sequencing controller that computes an unsigned 8x8 product by time-multiplexing a single 4x4 dadda_multiplier over four nibble sub-products. It shifts and accumulates those sub-products into a 16-bit result. It sits between an upstream valid/ready producer and a downstream valid/ready consumer. This lets the small Dadda datapath serve byte-wide operands without a larger tree.

---
 rtl/mul8_seq_pkg.sv | 32 +++
 rtl/mul8_seq_ctrl_if.sv | 31 +++
 rtl/dadda_multiplier.sv | 48 ++++
 rtl/mul8_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_mul8_seq_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul8_seq_pkg.sv
// ============================================================================
// Module   : mul8_seq_pkg
// Purpose  : Shared types and constants for the sequenced 8x8 multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul8_seq_pkg;

  localparam int OPND_W = 8;
  localparam int NIB_W  = 4;
  localparam int PROD_W = 16;
  localparam int STEP_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Left shift applied to each nibble sub-product, indexed by step
  localparam logic [3:0] SHIFT_TBL [0:3] = '{4'd0, 4'd4, 4'd4, 4'd8};

  function automatic logic [PROD_W-1:0] place_term(input logic [2*NIB_W-1:0] sub,
                                                   input logic [STEP_W-1:0]  step);
    return {{(PROD_W-2*NIB_W){1'b0}}, sub} << SHIFT_TBL[step];
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul8_seq_ctrl_if.sv
// ============================================================================
// Module   : mul8_seq_ctrl_if
// Purpose  : Operand-in / product-out valid-ready handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mul8_seq_ctrl_if;
  import mul8_seq_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [OPND_W-1:0]   a;
  logic [OPND_W-1:0]   b;
  logic                out_valid;
  logic                out_ready;
  logic [PROD_W-1:0]   product;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );

endinterface

`default_nettype wire

// File: rtl/dadda_multiplier.sv
// ============================================================================
// Module   : dadda_multiplier
// Purpose  : Unsigned 4x4 Dadda-tree multiplier, purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dadda_multiplier (
  output logic [7:0] s,
  input  logic [3:0] a,
  input  logic [3:0] b
);

  function automatic logic [1:0] ha(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  // pp[i][j] = a[i] & b[j], weight i+j
  logic [3:0] pp [0:3];

  for (genvar i = 0; i < 4; i++) begin : g_pp
    assign pp[i] = {4{a[i]}} & b;
  end

  // Stage 1: column heights reduced to at most 3
  logic s1_3, c1_4, s1_4, c1_5;
  assign {c1_4, s1_3} = ha(pp[3][0], pp[2][1]);
  assign {c1_5, s1_4} = ha(pp[3][1], pp[2][2]);

  // Stage 2: column heights reduced to at most 2
  logic s2_2, c2_3, s2_3, c2_4, s2_4, c2_5, s2_5, c2_6;
  assign {c2_3, s2_2} = ha(pp[2][0], pp[1][1]);
  assign {c2_4, s2_3} = fa(s1_3, pp[1][2], pp[0][3]);
  assign {c2_5, s2_4} = fa(s1_4, pp[1][3], c1_4);
  assign {c2_6, s2_5} = fa(pp[3][2], pp[2][3], c1_5);

  logic [7:0] w_row0, w_row1;
  assign w_row0 = {1'b0, pp[3][3], s2_5, s2_4, s2_3, s2_2, pp[1][0], pp[0][0]};
  assign w_row1 = {1'b0, c2_6, c2_5, c2_4, c2_3, pp[0][2], pp[0][1], 1'b0};
  assign s      = w_row0 + w_row1;

endmodule

`default_nettype wire

// File: rtl/mul8_seq_ctrl.sv
// ============================================================================
// Module   : mul8_seq_ctrl
// Purpose  : 8x8 unsigned multiply sequenced over one 4x4 Dadda multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul8_seq_ctrl
  import mul8_seq_pkg::*;
#(
  parameter int PIPE_MUL = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  mul8_seq_ctrl_if.slave   bus,
  input  logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  localparam bit HAS_PIPE = (PIPE_MUL != 0);

  state_t              r_state;
  logic [OPND_W-1:0]   r_a;
  logic [OPND_W-1:0]   r_b;
  logic [STEP_W-1:0]   r_step;
  logic [PROD_W-1:0]   r_acc;
  logic [PROD_W-1:0]   r_product;
  logic                r_out_valid;
  logic [CNT_W-1:0]    r_ops;

  logic [NIB_W-1:0]    w_nib_a;
  logic [NIB_W-1:0]    w_nib_b;
  logic [2*NIB_W-1:0]  w_sub;
  logic [PROD_W-1:0]   w_term;
  logic [PROD_W-1:0]   w_add_term;
  logic [PROD_W-1:0]   w_sum;
  logic                w_handshake;

  // step[0] picks the high multiplicand nibble, step[1] the high multiplier nibble
  assign w_nib_a = r_step[0] ? r_a[7:4] : r_a[3:0];
  assign w_nib_b = r_step[1] ? r_b[7:4] : r_b[3:0];

  dadda_multiplier u_mul (
    .s (w_sub),
    .a (w_nib_a),
    .b (w_nib_b)
  );

  assign w_term = place_term(w_sub, r_step);

  if (HAS_PIPE) begin : g_pipe
    logic [PROD_W-1:0] r_pipe;
    logic              r_pipe_vld;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_pipe     <= '0;
        r_pipe_vld <= 1'b0;
      end else begin
        r_pipe     <= w_term;
        r_pipe_vld <= (r_state == MUL) && !flush;
      end
    end

    // The first MUL cycle sees no valid term yet, so nothing is added
    assign w_add_term = r_pipe_vld ? r_pipe : '0;
  end else begin : g_comb
    assign w_add_term = w_term;
  end

  assign w_sum       = r_acc + w_add_term;
  assign w_handshake = r_out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_step      <= '0;
      r_acc       <= '0;
      r_product   <= '0;
      r_out_valid <= 1'b0;
      r_ops       <= '0;
    end else begin
      if (w_handshake) begin
        r_ops <= r_ops + CNT_W'(1);
      end

      if (flush && (r_state != IDLE)) begin
        r_state     <= IDLE;
        r_out_valid <= 1'b0;
        r_acc       <= '0;
        r_step      <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.in_valid && !flush) begin
              r_a     <= bus.a;
              r_b     <= bus.b;
              r_acc   <= '0;
              r_step  <= '0;
              r_state <= MUL;
            end
          end
          MUL: begin
            r_acc  <= w_sum;
            r_step <= r_step + STEP_W'(1);
            if (r_step == STEP_W'(3)) begin
              if (HAS_PIPE) begin
                r_state <= DRAIN;
              end else begin
                r_product   <= w_sum;
                r_out_valid <= 1'b1;
                r_state     <= DONE;
              end
            end
          end
          DRAIN: begin
            r_acc       <= w_sum;
            r_product   <= w_sum;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
          DONE: begin
            if (w_handshake) begin
              r_out_valid <= 1'b0;
              r_state     <= IDLE;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE) && !rst;
  assign bus.out_valid = r_out_valid;
  assign bus.product   = r_product;
  assign busy          = (r_state != IDLE);
  assign ops_done      = r_ops;

endmodule

`default_nettype wire

// File: tb/tb_mul8_seq_ctrl.sv
// ============================================================================
// Module   : tb_mul8_seq_ctrl
// Purpose  : Bench for mul8_seq_ctrl, lane 0 unpipelined, lane 1 pipelined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul8_seq_ctrl;

  localparam int NL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid_s  [NL];
  logic        out_ready_s [NL];
  logic        flush_s     [NL];
  logic [7:0]  a_s         [NL];
  logic [7:0]  b_s         [NL];
  logic        in_ready_s  [NL];
  logic        out_valid_s [NL];
  logic        busy_s      [NL];
  logic [15:0] product_s   [NL];
  logic [15:0] ops_s       [NL];

  for (genvar L = 0; L < NL; L++) begin : g_lane
    localparam int CW = (L == 0) ? 16 : 4;
    mul8_seq_ctrl_if bus ();
    logic [CW-1:0] od;

    assign bus.in_valid   = in_valid_s[L];
    assign bus.a          = a_s[L];
    assign bus.b          = b_s[L];
    assign bus.out_ready  = out_ready_s[L];
    assign in_ready_s[L]  = bus.in_ready;
    assign out_valid_s[L] = bus.out_valid;
    assign product_s[L]   = bus.product;
    assign ops_s[L]       = 16'(od);

    mul8_seq_ctrl #(.PIPE_MUL(L), .CNT_W(CW)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .flush    (flush_s[L]),
      .busy     (busy_s[L]),
      .ops_done (od)
    );
  end

  // Transaction-level reference: accepted pair yields a*b after 5+PIPE cycles
  int          m_now  [NL];
  bit          m_pend [NL];
  int          m_vat  [NL];
  logic [15:0] m_exp  [NL];
  logic [15:0] m_last [NL];
  int          m_ops  [NL];

  always @(posedge clk or posedge rst) begin : p_model
    if (rst) begin
      for (int l = 0; l < NL; l++) begin
        m_now[l]  <= 0;
        m_pend[l] <= 1'b0;
        m_vat[l]  <= 0;
        m_exp[l]  <= '0;
        m_last[l] <= '0;
        m_ops[l]  <= 0;
      end
    end else begin
      for (int l = 0; l < NL; l++) begin
        if (!m_pend[l]) begin
          if (in_valid_s[l] && !flush_s[l]) begin
            m_pend[l] <= 1'b1;
            m_exp[l]  <= {8'd0, a_s[l]} * {8'd0, b_s[l]};
            m_vat[l]  <= m_now[l] + 5 + l;
          end
        end else if ((m_now[l] >= m_vat[l]) && out_ready_s[l]) begin
          m_ops[l]  <= m_ops[l] + 1;
          m_pend[l] <= 1'b0;
        end else if (flush_s[l]) begin
          m_pend[l] <= 1'b0;
        end
        if (m_pend[l] && !flush_s[l] && (m_now[l] + 1 == m_vat[l]))
          m_last[l] <= m_exp[l];
        m_now[l] <= m_now[l] + 1;
      end
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int l = 0; l < NL; l++) begin
          logic [15:0] mask;
          logic [35:0] act, exp;
          mask = (l == 0) ? 16'hFFFF : 16'h000F;
          act  = {in_ready_s[l], out_valid_s[l], busy_s[l], product_s[l], ops_s[l]};
          exp  = {!m_pend[l], m_pend[l] && (m_now[l] >= m_vat[l]), m_pend[l],
                  m_last[l], 16'(m_ops[l]) & mask};
          n_vec++;
          if (act !== exp) begin
            n_bad++;
            $display("FAIL lane%0d cyc%0d {in_ready,out_valid,busy,product,ops}: got %0h, expected %0h",
                     l, m_now[l], act, exp);
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int l, input logic v, input logic [7:0] aa, input logic [7:0] bb);
    in_valid_s[l] = v;
    a_s[l]        = aa;
    b_s[l]        = bb;
  endtask

  // Counts cycles until out_valid is seen at a falling edge; 0 on timeout
  task automatic wait_ov(input int l, input int lim, output int n);
    n = 0;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (out_valid_s[l]) begin
        n = i;
        break;
      end
      tick();
    end
    chk("wait out_valid timeout", 32'(n != 0), 32'd1);
  endtask

  function automatic logic [7:0] pick();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 8'h00;
    if (r == 1) return 8'hFF;
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic drive_rand(input int l, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      drive(l, $urandom_range(0, 3) != 0, pick(), pick());
      out_ready_s[l] = 1'($urandom_range(0, 1));
      flush_s[l]     = ($urandom_range(0, 49) == 0);
    end
  endtask

  initial begin : p_main
    int  n;
    bit  seen;
    for (int l = 0; l < NL; l++) begin
      drive(l, 1'b0, 8'h00, 8'h00);
      out_ready_s[l] = 1'b0;
      flush_s[l]     = 1'b0;
    end
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("reset product", product_s[0], 16'h0000);
    chk("reset out_valid", out_valid_s[0], 1'b0);
    chk("reset busy", busy_s[0], 1'b0);
    chk("reset ops_done", ops_s[0], 16'h0000);
    chk("reset in_ready", in_ready_s[0], 1'b1);

    // 0xFF*0xFF, unpipelined: valid at T+5, idle again at T+6
    tick();
    out_ready_s[0] = 1'b1;
    drive(0, 1'b1, 8'hFF, 8'hFF);
    tick();
    drive(0, 1'b0, 8'h00, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("ffxff early valid", out_valid_s[0], 1'b0);
      tick();
    end
    @(negedge clk);
    chk("ffxff valid at T+5", out_valid_s[0], 1'b1);
    chk("ffxff product", product_s[0], 16'hFE01);
    tick();
    @(negedge clk);
    chk("ffxff in_ready at T+6", in_ready_s[0], 1'b1);
    chk("ffxff ops_done", ops_s[0], 16'd1);

    // 0x12*0x34 with back-pressure
    out_ready_s[0] = 1'b0;
    drive(0, 1'b1, 8'h12, 8'h34);
    tick();
    drive(0, 1'b0, 8'h00, 8'h00);
    wait_ov(0, 20, n);
    for (int k = 0; k < 3; k++) begin
      chk("stall product", product_s[0], 16'h03A8);
      chk("stall in_ready", in_ready_s[0], 1'b0);
      tick();
      @(negedge clk);
    end
    out_ready_s[0] = 1'b1;
    tick();
    @(negedge clk);
    chk("stall ops_done", ops_s[0], 16'd2);

    // Operand isolation: new request held on the bus during MUL
    drive(0, 1'b1, 8'hA5, 8'h3C);
    tick();
    drive(0, 1'b1, 8'h00, 8'h00);
    wait_ov(0, 20, n);
    chk("isolation product", product_s[0], 16'h26AC);
    tick();
    @(negedge clk);
    chk("second req waits for idle", in_ready_s[0], 1'b1);
    tick();
    drive(0, 1'b0, 8'h00, 8'h00);
    wait_ov(0, 20, n);
    chk("second req product", product_s[0], 16'h0000);
    tick();

    // flush during MUL step 2
    drive(0, 1'b1, 8'h55, 8'hAA);
    tick();
    drive(0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    flush_s[0] = 1'b1;
    tick();
    flush_s[0] = 1'b0;
    @(negedge clk);
    chk("flush busy", busy_s[0], 1'b0);
    chk("flush ops_done", ops_s[0], 16'd4);
    seen = 1'b0;
    repeat (8) begin
      tick();
      @(negedge clk);
      seen |= out_valid_s[0];
    end
    chk("flush no out_valid", seen, 1'b0);

    // flush with in_valid in IDLE is not an accept
    drive(0, 1'b1, 8'h0F, 8'hF0);
    flush_s[0] = 1'b1;
    tick();
    flush_s[0] = 1'b0;
    @(negedge clk);
    chk("idle flush blocks accept", busy_s[0], 1'b0);
    tick();
    drive(0, 1'b0, 8'h00, 8'h00);
    wait_ov(0, 20, n);
    chk("post-flush product", product_s[0], 16'h0E10);
    flush_s[0] = 1'b1;
    tick();
    flush_s[0] = 1'b0;
    @(negedge clk);
    chk("flush+handshake ops_done", ops_s[0], 16'd5);

    // Pipelined lane latency
    out_ready_s[1] = 1'b1;
    drive(1, 1'b1, 8'hFF, 8'hFF);
    tick();
    drive(1, 1'b0, 8'h00, 8'h00);
    wait_ov(1, 20, n);
    chk("pipe latency", n, 6);
    chk("pipe product", product_s[1], 16'hFE01);
    tick();

    // Async reset mid-operation
    drive(0, 1'b1, 8'h77, 8'h99);
    tick();
    drive(0, 1'b0, 8'h00, 8'h00);
    tick();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async rst busy", busy_s[0], 1'b0);
    chk("async rst out_valid", out_valid_s[0], 1'b0);
    chk("async rst ops_done", ops_s[0], 16'd0);
    chk("async rst product", product_s[0], 16'h0000);
    #1 rst = 1'b0;
    #1;
    chk("post rst in_ready", in_ready_s[0], 1'b1);

    fork
      drive_rand(0, 20000);
      drive_rand(1, 20000);
    join
    for (int l = 0; l < NL; l++) begin
      drive(l, 1'b0, 8'h00, 8'h00);
      out_ready_s[l] = 1'b1;
      flush_s[l]     = 1'b0;
    end
    repeat (12) tick();
    @(negedge clk);
    chk("drain lane0 idle", busy_s[0], 1'b0);
    chk("drain lane1 idle", busy_s[1], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
